// File: rtl/qea_run_controller.sv
// rtl/qea_run_controller.sv - run sequencer: context load, state init, start/wait, state readback
module qea_run_controller #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int NUM_FRAC_BIT            = 30,
    parameter int CYCLE_CNT_WIDTH         = 32,
    parameter int RD_LAT                  = 1
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       i_run,
    input  logic [MAX_QBIT_WIDTH-1:0]                  i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH:0]           i_ins_num,
    input  logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0]   i_init_basis,
    input  logic [CYCLE_CNT_WIDTH-1:0]                 i_timeout,
    input  logic                                       i_ctx_valid,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]         i_ctx_data,
    output logic                                       o_ctx_ready,
    output logic                                       o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]                  o_qbit_num,
    output logic                                       o_ctx_en,
    output logic                                       o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]         o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]         o_ctx_data,
    output logic [PE_NUM-1:0]                          o_state_ena,
    output logic [PE_NUM-1:0]                          o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]                o_state_addra,
    output logic [PE_NUM*2*DATA_WIDTH-1:0]             o_state_dina,
    input  logic                                       i_qea_complete,
    input  logic [PE_NUM*2*DATA_WIDTH-1:0]             i_qea_state_dout,
    output logic                                       o_rd_valid,
    output logic [STATE_ADDR_WIDTH-1:0]                o_rd_addr,
    output logic [PE_NUM*2*DATA_WIDTH-1:0]             o_rd_data,
    output logic                                       o_busy,
    output logic                                       o_done,
    output logic                                       o_timeout,
    output logic                                       o_err,
    output logic [CYCLE_CNT_WIDTH-1:0]                 o_cycle_cnt
);
    localparam int SDW = 2 * DATA_WIDTH;
    localparam int BW  = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
    localparam int RW  = STATE_ADDR_WIDTH + 1;
    localparam logic [MAX_QBIT_WIDTH-1:0] QMIN = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    localparam logic [MAX_QBIT_WIDTH-1:0] QMAX = MAX_QBIT_WIDTH'(BW);
    localparam logic [DATA_WIDTH-1:0] ONE_RE = DATA_WIDTH'(1) << NUM_FRAC_BIT;
    localparam logic [SDW-1:0] ONE_SLICE = {ONE_RE, {DATA_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_CTX_LOAD, S_STATE_INIT, S_START, S_WAIT, S_READBACK, S_DONE
    } state_t;

    state_t state, next_state;

    logic [MAX_QBIT_WIDTH-1:0]          qbit_r;
    logic [GATE_CONTEXT_ADDR_WIDTH:0]   ins_r;
    logic [BW-1:0]                      basis_r;
    logic [CYCLE_CNT_WIDTH-1:0]         tmo_r;
    logic [CYCLE_CNT_WIDTH-1:0]         cyc_cnt;
    logic [CYCLE_CNT_WIDTH-1:0]         cnt_inc;
    logic [GATE_CONTEXT_ADDR_WIDTH:0]   ctx_cnt;
    logic [RW-1:0]                      row_cnt;
    logic [RW-1:0]                      rows;
    logic [BW-1:0]                      basis_m;
    logic [STATE_ADDR_WIDTH-1:0]        hot_row;
    logic [PE_NUM_WIDTH-1:0]            hot_lane;
    logic [PE_NUM*SDW-1:0]              hot_dina;
    logic                               timeout_r, err_r, rd_port_q;
    logic                               run_ok, ctx_hs, ctx_last, init_last, rd_issue, drained, tmo_hit;
    logic [RD_LAT-1:0]                  pipe_v;
    logic [RD_LAT-1:0][STATE_ADDR_WIDTH-1:0] pipe_a;

    assign run_ok    = i_run && (i_qbit_num >= QMIN) && (i_qbit_num <= QMAX);
    assign rows      = RW'(1) << (qbit_r - QMIN);
    assign basis_m   = basis_r & ~({BW{1'b1}} << qbit_r);
    assign hot_row   = basis_m[BW-1:PE_NUM_WIDTH];
    assign hot_lane  = basis_m[PE_NUM_WIDTH-1:0];
    assign ctx_hs    = (state == S_CTX_LOAD) && i_ctx_valid;
    assign ctx_last  = (ctx_cnt + 1'b1) == ins_r;
    assign init_last = (row_cnt + 1'b1) == rows;
    assign rd_issue  = (state == S_READBACK) && (row_cnt != rows);
    assign drained   = (row_cnt == rows) && !rd_port_q && (pipe_v == '0);
    assign cnt_inc   = (&cyc_cnt) ? cyc_cnt : cyc_cnt + 1'b1;
    assign tmo_hit   = (tmo_r != '0) && (cnt_inc >= tmo_r);

    assign o_ctx_ready = (state == S_CTX_LOAD);
    assign o_qea_start = (state == S_START);
    assign o_done      = (state == S_DONE);
    assign o_busy      = (state != S_IDLE);
    assign o_qbit_num  = qbit_r;
    assign o_timeout   = timeout_r;
    assign o_err       = err_r;
    assign o_cycle_cnt = cyc_cnt;
    assign o_rd_valid  = pipe_v[RD_LAT-1];
    assign o_rd_addr   = pipe_v[RD_LAT-1] ? pipe_a[RD_LAT-1] : '0;
    assign o_rd_data   = pipe_v[RD_LAT-1] ? i_qea_state_dout : '0;

    // Row image with amplitude 1.0 in the selected lane; lane 0 is the most significant slice.
    always_comb begin
        hot_dina = '0;
        for (int l = 0; l < PE_NUM; l++) begin
            if (hot_lane == PE_NUM_WIDTH'(l)) begin
                hot_dina[(PE_NUM-1-l)*SDW +: SDW] = ONE_SLICE;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:       if (run_ok) next_state = (i_ins_num == '0) ? S_STATE_INIT : S_CTX_LOAD;
            S_CTX_LOAD:   if (ctx_hs && ctx_last) next_state = S_STATE_INIT;
            S_STATE_INIT: if (init_last) next_state = S_START;
            S_START:      next_state = S_WAIT;
            S_WAIT: begin
                if (i_qea_complete) next_state = S_READBACK;
                else if (tmo_hit)   next_state = S_DONE;
            end
            S_READBACK:   if (drained) next_state = S_DONE;
            S_DONE:       next_state = S_IDLE;
            default:      next_state = S_IDLE;
        endcase
    end

    // Run parameters, counters and registered RAM-side ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qbit_r <= '0; ins_r <= '0; basis_r <= '0; tmo_r <= '0;
            cyc_cnt <= '0; ctx_cnt <= '0; row_cnt <= '0;
            timeout_r <= 1'b0; err_r <= 1'b0; rd_port_q <= 1'b0;
            o_ctx_en <= 1'b0; o_ctx_wea <= 1'b0; o_ctx_addr <= '0; o_ctx_data <= '0;
            o_state_ena <= '0; o_state_wea <= '0; o_state_addra <= '0; o_state_dina <= '0;
            pipe_v <= '0; pipe_a <= '0;
        end else begin
            err_r       <= 1'b0;
            o_ctx_en    <= 1'b0;
            o_ctx_wea   <= 1'b0;
            o_state_ena <= '0;
            o_state_wea <= '0;
            rd_port_q   <= rd_issue;
            case (state)
                S_IDLE: begin
                    if (i_run) begin
                        qbit_r  <= i_qbit_num;
                        ins_r   <= i_ins_num;
                        basis_r <= i_init_basis;
                        tmo_r   <= i_timeout;
                        if (run_ok) begin
                            ctx_cnt   <= '0;
                            row_cnt   <= '0;
                            cyc_cnt   <= '0;
                            timeout_r <= 1'b0;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                S_CTX_LOAD: begin
                    if (ctx_hs) begin
                        o_ctx_en   <= 1'b1;
                        o_ctx_wea  <= 1'b1;
                        o_ctx_addr <= ctx_cnt[GATE_CONTEXT_ADDR_WIDTH-1:0];
                        o_ctx_data <= i_ctx_data;
                        ctx_cnt    <= ctx_cnt + 1'b1;
                    end
                end
                S_STATE_INIT: begin
                    o_state_ena   <= '1;
                    o_state_wea   <= '1;
                    o_state_addra <= row_cnt[STATE_ADDR_WIDTH-1:0];
                    o_state_dina  <= (row_cnt[STATE_ADDR_WIDTH-1:0] == hot_row) ? hot_dina : '0;
                    row_cnt       <= row_cnt + 1'b1;
                end
                S_START: begin
                    cyc_cnt <= '0;
                    row_cnt <= '0;
                end
                S_WAIT: begin
                    cyc_cnt <= cnt_inc;
                    if (!i_qea_complete && tmo_hit) timeout_r <= 1'b1;
                end
                S_READBACK: begin
                    if (rd_issue) begin
                        o_state_ena   <= '1;
                        o_state_addra <= row_cnt[STATE_ADDR_WIDTH-1:0];
                        row_cnt       <= row_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            pipe_v[0] <= rd_port_q;
            pipe_a[0] <= o_state_addra;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end
        end
    end
endmodule

// File: tb/tb_qea_run_controller.sv
// tb/tb_qea_run_controller.sv - scoreboard bench for qea_run_controller
module tb_qea_run_controller;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_run;
    logic [5:0]   i_qbit_num;
    logic [16:0]  i_ins_num;
    logic [17:0]  i_init_basis;
    logic [31:0]  i_timeout;
    logic         i_ctx_valid;
    logic [63:0]  i_ctx_data;
    logic         o_ctx_ready, o_qea_start;
    logic [5:0]   o_qbit_num;
    logic         o_ctx_en, o_ctx_wea;
    logic [15:0]  o_ctx_addr;
    logic [63:0]  o_ctx_data;
    logic [3:0]   o_state_ena, o_state_wea;
    logic [15:0]  o_state_addra;
    logic [255:0] o_state_dina;
    logic         i_qea_complete;
    logic [255:0] i_qea_state_dout;
    logic         o_rd_valid;
    logic [15:0]  o_rd_addr;
    logic [255:0] o_rd_data;
    logic         o_busy, o_done, o_timeout, o_err;
    logic [31:0]  o_cycle_cnt;

    always #5 clk = ~clk;

    qea_run_controller dut (
        .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_qbit_num(i_qbit_num),
        .i_ins_num(i_ins_num), .i_init_basis(i_init_basis), .i_timeout(i_timeout),
        .i_ctx_valid(i_ctx_valid), .i_ctx_data(i_ctx_data), .o_ctx_ready(o_ctx_ready),
        .o_qea_start(o_qea_start), .o_qbit_num(o_qbit_num),
        .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
        .o_state_dina(o_state_dina), .i_qea_complete(i_qea_complete),
        .i_qea_state_dout(i_qea_state_dout), .o_rd_valid(o_rd_valid), .o_rd_addr(o_rd_addr),
        .o_rd_data(o_rd_data), .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout),
        .o_err(o_err), .o_cycle_cnt(o_cycle_cnt)
    );

    typedef struct {
        logic [15:0]  addr;
        logic [255:0] data;
    } exp_t;

    exp_t q_ctx[$];
    exp_t q_init[$];
    exp_t q_rd[$];
    exp_t m_e;

    int n_checks = 0;
    int n_pass = 0;
    int done_cnt = 0, err_cnt = 0, rd_cnt = 0, start_cnt = 0, ctx_en_cnt = 0;
    int cur_rows, cur_b, cur_qb;
    logic [4:0]   pat = 5'b11001;
    logic [255:0] one = 256'h4000_0000_0000_0000;
    logic [255:0] row_img [0:63];
    logic [255:0] mem [0:63];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // State RAM model with one-cycle read latency.
    always @(posedge clk) begin
        if (o_state_ena != 4'h0) begin
            if (o_state_wea != 4'h0) mem[o_state_addra[5:0]] <= o_state_dina;
            else                     i_qea_state_dout <= mem[o_state_addra[5:0]];
        end
    end

    // Output monitor: pops scoreboard entries as the DUT produces them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_ctx_en) begin
                ctx_en_cnt++;
                check("ctx_pending", 256'(q_ctx.size() != 0), 256'(1));
                check("ctx_wea", 256'(o_ctx_wea), 256'(1));
                if (q_ctx.size() != 0) begin
                    m_e = q_ctx.pop_front();
                    check("ctx_addr", 256'(o_ctx_addr), 256'(m_e.addr));
                    check("ctx_data", 256'(o_ctx_data), m_e.data);
                end
            end
            if (o_state_ena != 4'h0 && o_state_wea != 4'h0) begin
                check("init_pending", 256'(q_init.size() != 0), 256'(1));
                check("init_ena", 256'({o_state_ena, o_state_wea}), 256'(8'hff));
                if (q_init.size() != 0) begin
                    m_e = q_init.pop_front();
                    check("init_addr", 256'(o_state_addra), 256'(m_e.addr));
                    check("init_dina", o_state_dina, m_e.data);
                end
            end
            if (o_rd_valid) begin
                rd_cnt++;
                check("rd_pending", 256'(q_rd.size() != 0), 256'(1));
                if (q_rd.size() != 0) begin
                    m_e = q_rd.pop_front();
                    check("rd_addr", 256'(o_rd_addr), 256'(m_e.addr));
                    check("rd_data", o_rd_data, m_e.data);
                end
            end
            if (o_done) done_cnt++;
            if (o_err) err_cnt++;
            if (o_qea_start) start_cnt++;
        end
    end

    task automatic launch(input int qb, input int ins, input int basis, input int tmo);
        exp_t e;
        int n, k;
        cur_qb = qb;
        cur_rows = 1 << (qb - 2);
        cur_b = basis & ((1 << qb) - 1);
        for (int r = 0; r < cur_rows; r++) begin
            row_img[r] = (r == (cur_b >> 2)) ? (one << (64 * (3 - (cur_b & 3)))) : 256'h0;
            e.addr = 16'(r);
            e.data = row_img[r];
            q_init.push_back(e);
        end
        @(posedge clk); #1;
        i_qbit_num = 6'(qb); i_ins_num = 17'(ins); i_init_basis = 18'(basis); i_timeout = 32'(tmo);
        i_run = 1'b1;
        @(posedge clk); #1;
        i_run = 1'b0;
        n = 0;
        k = 0;
        while (n < ins && k < 200) begin
            i_ctx_valid = pat[k % 5];
            i_ctx_data = {$urandom, $urandom};
            @(negedge clk);
            if (i_ctx_valid && o_ctx_ready) begin
                e.addr = 16'(n);
                e.data = 256'(i_ctx_data);
                q_ctx.push_back(e);
                n++;
            end
            @(posedge clk); #1;
            k++;
        end
        i_ctx_valid = 1'b0;
        check("ctx_accepted", 256'(n), 256'(ins));
    endtask

    task automatic wait_start();
        int t = 0;
        while (!o_qea_start && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("start_seen", 256'(o_qea_start), 256'(1));
    endtask

    task automatic finish_run(input int cdel, input bit inj);
        exp_t e;
        int t = 0;
        if (cdel >= 0) begin
            for (int r = 0; r < cur_rows; r++) begin
                e.addr = 16'(r);
                e.data = row_img[r];
                q_rd.push_back(e);
            end
            if (inj) begin
                @(posedge clk); #1;
                i_run = 1'b1; i_qbit_num = 6'd4;
                @(posedge clk); #1;
                i_run = 1'b0;
                @(negedge clk);
                check("busy_in_wait", 256'(o_busy), 256'(1));
                check("run_ignored_qbit", 256'(o_qbit_num), 256'(cur_qb));
                repeat (cdel - 2) @(posedge clk);
            end else begin
                repeat (cdel) @(posedge clk);
            end
            #1 i_qea_complete = 1'b1;
            @(posedge clk); #1;
            i_qea_complete = 1'b0;
        end
        while (!o_done && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", 256'(o_done), 256'(1));
        @(negedge clk);
        check("done_pulse_end", 256'(o_done), 256'(0));
        check("idle_after_done", 256'(o_busy), 256'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int d0, r0, s0, c0, e0;
        rst_n = 1'b0; i_run = 1'b0; i_qbit_num = '0; i_ins_num = '0; i_init_basis = '0;
        i_timeout = '0; i_ctx_valid = 1'b0; i_ctx_data = '0; i_qea_complete = 1'b0;
        i_qea_state_dout = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 256'({o_busy, o_done, o_timeout, o_err, o_qea_start, o_ctx_ready,
              o_ctx_en, o_state_ena, o_rd_valid, o_qbit_num, o_cycle_cnt}), 256'(0));
        rst_n = 1'b1;

        // Run A: 6 qubits, 3 context words with gappy valid, basis 0, complete after 50.
        d0 = done_cnt; r0 = rd_cnt; s0 = start_cnt; c0 = ctx_en_cnt;
        launch(6, 3, 0, 0);
        wait_start();
        finish_run(50, 1'b1);
        check("a_cycle_cnt", 256'(o_cycle_cnt), 256'(50));
        check("a_timeout", 256'(o_timeout), 256'(0));
        check("a_done_count", 256'(done_cnt - d0), 256'(1));
        check("a_rd_count", 256'(rd_cnt - r0), 256'(16));
        check("a_start_count", 256'(start_cnt - s0), 256'(1));
        check("a_ctx_en_count", 256'(ctx_en_cnt - c0), 256'(3));
        check("a_qbit_num", 256'(o_qbit_num), 256'(6));
        check("a_queues_empty", 256'(q_ctx.size() + q_init.size() + q_rd.size()), 256'(0));

        // Run B: basis 5 lands in row 1, lane 1.
        d0 = done_cnt; r0 = rd_cnt;
        launch(6, 2, 5, 0);
        wait_start();
        finish_run(30, 1'b0);
        check("b_cycle_cnt", 256'(o_cycle_cnt), 256'(30));
        check("b_rd_count", 256'(rd_cnt - r0), 256'(16));
        check("b_done_count", 256'(done_cnt - d0), 256'(1));
        check("b_queues_empty", 256'(q_ctx.size() + q_init.size() + q_rd.size()), 256'(0));

        // Run C: timeout 20, complete never arrives; basis above range is masked.
        d0 = done_cnt; r0 = rd_cnt;
        launch(5, 1, 70, 20);
        wait_start();
        finish_run(-1, 1'b0);
        check("c_timeout", 256'(o_timeout), 256'(1));
        check("c_cycle_cnt", 256'(o_cycle_cnt), 256'(20));
        check("c_no_readback", 256'(rd_cnt - r0), 256'(0));
        check("c_done_count", 256'(done_cnt - d0), 256'(1));

        // Run D: out-of-range qubit counts raise o_err and never start.
        e0 = err_cnt;
        for (int q = 0; q < 2; q++) begin
            @(posedge clk); #1;
            i_qbit_num = (q == 0) ? 6'd1 : 6'd19;
            i_run = 1'b1;
            @(posedge clk); #1;
            i_run = 1'b0;
            @(negedge clk);
            check("d_busy_low", 256'(o_busy), 256'(0));
            @(negedge clk);
        end
        check("d_err_count", 256'(err_cnt - e0), 256'(2));
        check("d_timeout_held", 256'(o_timeout), 256'(1));

        // Run E: asynchronous reset while waiting, then a clean run.
        d0 = done_cnt;
        launch(6, 1, 3, 0);
        wait_start();
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("e_async_reset", 256'({o_busy, o_done, o_timeout, o_err, o_qea_start, o_ctx_ready,
              o_ctx_en, o_state_ena, o_rd_valid, o_rd_data, o_cycle_cnt}), 256'(0));
        q_rd.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("e_no_done", 256'(done_cnt - d0), 256'(0));
        r0 = rd_cnt;
        launch(6, 2, 7, 0);
        wait_start();
        finish_run(10, 1'b0);
        check("e_cycle_cnt", 256'(o_cycle_cnt), 256'(10));
        check("e_rd_count", 256'(rd_cnt - r0), 256'(16));
        check("e_done_count", 256'(done_cnt - d0), 256'(1));
        check("e_queues_empty", 256'(q_ctx.size() + q_init.size() + q_rd.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
